// File: rtl/cb_nchan.sv
// ----------------------------------------------------------------------------
// cb_nchan -- N-channel connection box with per-LE serial configuration.
//
// Each attached logic element (LE) owns a serial config chain: a shadow shift
// register loaded bit-serially, and an active register that drives routing.
// A commit copies all shadows into their active registers at once, but only
// when exactly CHAIN_LEN bits were shifted since the last commit/reset.
//
// Optional feature macro: CB_PARITY_EN
//   When defined, every chain carries one extra parity bit at bit 0 (the last
//   bit shifted in). A commit additionally requires even parity over each
//   whole chain.
//
// Ports:
//   clk             clock, all state on rising edge
//   nrst            asynchronous active-low reset
//   config_en       shift enable for all chains
//   config_data_in  [NUM_LE]   serial config bit per chain
//   config_data_out [NUM_LE]   shadow MSB per chain (daisy-chain out)
//   commit          request shadow -> active copy
//   config_done     one-cycle pulse after a successful commit
//   config_err      sticky error flag (cleared by reset or good commit)
//   sb_bus_in/out   [WIDTH]    switchbox-side tracks
//   cb_bus_in/out   [WIDTH]    neighbour-CB-side tracks
//   le_out          [NUM_LE*LE_OUTPUTS]  LE outputs (LE k at k*LE_OUTPUTS)
//   le_in           [NUM_LE*LE_INPUTS]   LE inputs  (LE k at k*LE_INPUTS)
// ----------------------------------------------------------------------------

// Per-LE slice: config chain (shadow + active) and the LE input muxes.
// Output-mux selectors are exported because track drive priority spans LEs.
module cb_le_slice #(
    parameter int WIDTH      = 32,
    parameter int LE_INPUTS  = 4,
    parameter int LE_OUTPUTS = 1,
    parameter int SEL_BITS   = 6,
    parameter int PAR_BITS   = 0
) (
    input  logic                                 clk,
    input  logic                                 nrst,
    input  logic                                 shift,
    input  logic                                 load,
    input  logic                                 din,
    input  logic                                 route_en,
    input  logic [WIDTH-1:0]                     sb_bus_in,
    input  logic [WIDTH-1:0]                     cb_bus_in,
    output logic                                 dout,
    output logic                                 par_odd,
    output logic [LE_INPUTS-1:0]                 le_in,
    output logic [LE_OUTPUTS-1:0][SEL_BITS-1:0]  out_sel
);
    localparam int NMUX      = LE_INPUTS + LE_OUTPUTS;
    localparam int SEL_W     = SEL_BITS * NMUX;
    localparam int CHAIN_LEN = SEL_W + PAR_BITS;

    localparam logic [SEL_BITS-1:0] SEL_ONE = SEL_BITS'(WIDTH + 1);

    logic [CHAIN_LEN-1:0] shadow;
    // The parity bit never reaches the active register; routing only needs
    // the selector fields.
    logic [SEL_W-1:0]     active;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shadow <= '1;
            active <= '1;
        end else begin
            if (shift)
                shadow <= {shadow[CHAIN_LEN-2:0], din};
            if (load)
                active <= shadow[CHAIN_LEN-1:PAR_BITS];
        end
    end

    assign dout = shadow[CHAIN_LEN-1];

    generate
        if (PAR_BITS > 0) begin : g_par
            assign par_odd = ^shadow;
        end else begin : g_nopar
            assign par_odd = 1'b0;
        end
    endgenerate

    genvar o;
    generate
        for (o = 0; o < LE_OUTPUTS; o++) begin : g_osel
            assign out_sel[o] = active[(LE_INPUTS+o+1)*SEL_BITS-1 -: SEL_BITS];
        end
    endgenerate

    // Input mux: tracks 0..WIDTH-1 take the OR of both bus sides, WIDTH+1 is
    // constant one, WIDTH and anything above WIDTH+1 read as zero.
    always_comb begin
        logic [SEL_BITS-1:0] s;
        s     = '0;
        le_in = '0;
        for (int i = 0; i < LE_INPUTS; i++) begin
            s = active[(i+1)*SEL_BITS-1 -: SEL_BITS];
            if (route_en) begin
                if (s == SEL_ONE)
                    le_in[i] = 1'b1;
                for (int j = 0; j < WIDTH; j++) begin
                    if (s == SEL_BITS'(j))
                        le_in[i] = sb_bus_in[j] | cb_bus_in[j];
                end
            end
        end
    end
endmodule

module cb_nchan #(
    parameter int WIDTH      = 32,
    parameter int NUM_LE     = 2,
    parameter int LE_INPUTS  = 4,
    parameter int LE_OUTPUTS = 1
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          config_en,
    input  logic [NUM_LE-1:0]             config_data_in,
    output logic [NUM_LE-1:0]             config_data_out,
    input  logic                          commit,
    output logic                          config_done,
    output logic                          config_err,
    input  logic [WIDTH-1:0]              sb_bus_in,
    output logic [WIDTH-1:0]              sb_bus_out,
    input  logic [WIDTH-1:0]              cb_bus_in,
    output logic [WIDTH-1:0]              cb_bus_out,
    input  logic [NUM_LE*LE_OUTPUTS-1:0]  le_out,
    output logic [NUM_LE*LE_INPUTS-1:0]   le_in
);
    localparam int SEL_BITS = $clog2(WIDTH + 2);
    localparam int NMUX     = LE_INPUTS + LE_OUTPUTS;
`ifdef CB_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int CHAIN_LEN = SEL_BITS * NMUX + PAR_BITS;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOADING = 2'd1,
        S_ACTIVE  = 2'd2,
        S_ERROR   = 2'd3
    } state_t;

    state_t                                         state;
    logic [CNT_W-1:0]                               cnt;
    logic [NUM_LE-1:0]                              par_odd;
    logic [NUM_LE-1:0][LE_OUTPUTS-1:0][SEL_BITS-1:0] out_sel;
    logic                                           route_en;
    logic                                           commit_ok;
    logic                                           load;

    // Routing stays dormant until the first configuration attempt after
    // reset, whatever the active registers hold.
    assign route_en  = (state != S_IDLE);
    // par_odd is tied low when parity is not built in.
    assign commit_ok = (cnt == CNT_FULL) && !(|par_odd);
    // A commit coinciding with a shift is an error, so load and shift are
    // never asserted together.
    assign load      = commit && !config_en && (state == S_LOADING) && commit_ok;

    genvar k;
    generate
        for (k = 0; k < NUM_LE; k++) begin : g_le
            cb_le_slice #(
                .WIDTH      (WIDTH),
                .LE_INPUTS  (LE_INPUTS),
                .LE_OUTPUTS (LE_OUTPUTS),
                .SEL_BITS   (SEL_BITS),
                .PAR_BITS   (PAR_BITS)
            ) u_slice (
                .clk       (clk),
                .nrst      (nrst),
                .shift     (config_en),
                .load      (load),
                .din       (config_data_in[k]),
                .route_en  (route_en),
                .sb_bus_in (sb_bus_in),
                .cb_bus_in (cb_bus_in),
                .dout      (config_data_out[k]),
                .par_odd   (par_odd[k]),
                .le_in     (le_in[k*LE_INPUTS +: LE_INPUTS]),
                .out_sel   (out_sel[k])
            );
        end
    endgenerate

    // Config control FSM. The counter tracks bits shifted since the last
    // commit/reset and saturates one past CHAIN_LEN so overshoot stays wrong.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            config_done <= 1'b0;
            config_err  <= 1'b0;
        end else begin
            config_done <= 1'b0;
            if (config_en) begin
                if (state != S_LOADING)
                    cnt <= CNT_W'(1);
                else if (cnt != CNT_SAT)
                    cnt <= cnt + 1'b1;
                if (commit) begin
                    config_err <= 1'b1;
                    state      <= S_ERROR;
                end else begin
                    state      <= S_LOADING;
                end
            end else if (commit && state == S_LOADING) begin
                cnt <= '0;
                if (commit_ok) begin
                    config_done <= 1'b1;
                    config_err  <= 1'b0;
                    state       <= S_ACTIVE;
                end else begin
                    config_err  <= 1'b1;
                    state       <= S_ERROR;
                end
            end
        end
    end

    // Track drive: default is cross pass-through; the first LE output (LE
    // order, then output order) selecting track j overrides both sides.
    always_comb begin
        logic hit;
        hit        = 1'b0;
        sb_bus_out = cb_bus_in;
        cb_bus_out = sb_bus_in;
        if (route_en) begin
            for (int j = 0; j < WIDTH; j++) begin
                hit = 1'b0;
                for (int n = 0; n < NUM_LE; n++) begin
                    for (int o = 0; o < LE_OUTPUTS; o++) begin
                        if (!hit && out_sel[n][o] == SEL_BITS'(j)) begin
                            hit           = 1'b1;
                            sb_bus_out[j] = le_out[n*LE_OUTPUTS+o];
                            cb_bus_out[j] = le_out[n*LE_OUTPUTS+o];
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_cb_nchan.sv
// ----------------------------------------------------------------------------
// tb_cb_nchan -- randomized bench for cb_nchan (WIDTH=8, NUM_LE=2,
// LE_INPUTS=4, LE_OUTPUTS=1). A behavioural model tracks the shadow bits,
// decoded selectors and config state; routing expectations are computed
// from the selector rules directly.
// ----------------------------------------------------------------------------
module tb_cb_nchan;
    localparam int W  = 8;
    localparam int NL = 2;
    localparam int NI = 4;
    localparam int NO = 1;
    localparam int SB = 4;
    localparam int NM = NI + NO;
`ifdef CB_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int CL = SB * NM + PB;

    logic              clk = 1'b0;
    logic              nrst;
    logic              config_en;
    logic [NL-1:0]     config_data_in;
    logic [NL-1:0]     config_data_out;
    logic              commit;
    logic              config_done;
    logic              config_err;
    logic [W-1:0]      sb_bus_in, sb_bus_out, cb_bus_in, cb_bus_out;
    logic [NL*NO-1:0]  le_out;
    logic [NL*NI-1:0]  le_in;

    cb_nchan #(.WIDTH(W), .NUM_LE(NL), .LE_INPUTS(NI), .LE_OUTPUTS(NO)) dut (
        .clk             (clk),
        .nrst            (nrst),
        .config_en       (config_en),
        .config_data_in  (config_data_in),
        .config_data_out (config_data_out),
        .commit          (commit),
        .config_done     (config_done),
        .config_err      (config_err),
        .sb_bus_in       (sb_bus_in),
        .sb_bus_out      (sb_bus_out),
        .cb_bus_in       (cb_bus_in),
        .cb_bus_out      (cb_bus_out),
        .le_out          (le_out),
        .le_in           (le_in)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // model state: 0 idle, 1 loading, 2 active, 3 error
    int m_state;
    int m_cnt;
    bit m_done, m_err;
    bit m_sh[NL][CL];
    int m_sel[NL][NM];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NL; k++) begin
            for (int b = 0; b < CL; b++) m_sh[k][b] = 1'b1;
            for (int m = 0; m < NM; m++) m_sel[k][m] = (1 << SB) - 1;
        end
        m_state = 0; m_cnt = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step(input bit en, input bit [NL-1:0] d, input bit cm);
        bit ok, par;
        int v;
        m_done = 0;
        if (en) begin
            for (int k = 0; k < NL; k++) begin
                for (int b = CL - 1; b > 0; b--) m_sh[k][b] = m_sh[k][b-1];
                m_sh[k][0] = d[k];
            end
            if (m_state != 1) m_cnt = 1;
            else if (m_cnt < CL + 1) m_cnt++;
            if (cm) begin m_err = 1; m_state = 3; end
            else m_state = 1;
        end else if (cm && m_state == 1) begin
            ok = (m_cnt == CL);
            for (int k = 0; k < NL; k++) begin
                par = 0;
                for (int b = 0; b < CL; b++) par ^= m_sh[k][b];
                if (PB == 1 && par) ok = 0;
            end
            m_cnt = 0;
            if (ok) begin
                for (int k = 0; k < NL; k++)
                    for (int m = 0; m < NM; m++) begin
                        v = 0;
                        for (int b = (m+1)*SB - 1; b >= m*SB; b--) v = v*2 + int'(m_sh[k][b+PB]);
                        m_sel[k][m] = v;
                    end
                m_done = 1; m_err = 0; m_state = 2;
            end else begin
                m_err = 1; m_state = 3;
            end
        end
    endtask

    task automatic check_ctl();
        logic [NL-1:0] e_dout;
        for (int k = 0; k < NL; k++) e_dout[k] = m_sh[k][CL-1];
        chk("config_done", 32'(config_done), 32'(m_done));
        chk("config_err", 32'(config_err), 32'(m_err));
        chk("config_data_out", 32'(config_data_out), 32'(e_dout));
    endtask

    task automatic check_route();
        logic [NL*NI-1:0] e_in;
        logic [W-1:0]     e_sb, e_cb;
        bit               done_j;
        int               s;
        sb_bus_in = W'($urandom);
        cb_bus_in = W'($urandom);
        le_out    = NL'($urandom);
        #1;
        e_in = '0;
        e_sb = cb_bus_in;
        e_cb = sb_bus_in;
        if (m_state != 0) begin
            for (int k = 0; k < NL; k++)
                for (int i = 0; i < NI; i++) begin
                    s = m_sel[k][i];
                    if (s < W)          e_in[k*NI+i] = sb_bus_in[s] | cb_bus_in[s];
                    else if (s == W+1)  e_in[k*NI+i] = 1'b1;
                end
            for (int j = 0; j < W; j++) begin
                done_j = 0;
                for (int k = 0; k < NL; k++)
                    if (!done_j && m_sel[k][NI] == j) begin
                        done_j  = 1;
                        e_sb[j] = le_out[k];
                        e_cb[j] = le_out[k];
                    end
            end
        end
        chk("le_in", 32'(le_in), 32'(e_in));
        chk("sb_bus_out", 32'(sb_bus_out), 32'(e_sb));
        chk("cb_bus_out", 32'(cb_bus_out), 32'(e_cb));
    endtask

    task automatic cyc(input bit en, input bit [NL-1:0] d, input bit cm);
        config_en = en; config_data_in = d; commit = cm;
        @(posedge clk);
        model_step(en, d, cm);
        #1;
        config_en = 0; commit = 0;
        check_ctl();
        check_route();
    endtask

    function automatic logic [SB*NM-1:0] mkw(input int s0, s1, s2, s3, s4);
        return {4'(s4), 4'(s3), 4'(s2), 4'(s1), 4'(s0)};
    endfunction

    // cmode: 0 no commit, 1 commit on following cycle, 2 commit with last shift
    task automatic cfg(input logic [SB*NM-1:0] w0, w1, input int nbits, input bit bad, input int cmode);
        logic [CL-1:0]    f[NL];
        logic [SB*NM:0]   ext;
        logic [SB*NM-1:0] wk;
        bit   [NL-1:0]    d;
        int               idx;
        for (int k = 0; k < NL; k++) begin
            wk   = (k == 0) ? w0 : w1;
            ext  = {wk, ^wk ^ bad};
            f[k] = (PB == 1) ? CL'(ext) : CL'(ext >> 1);
        end
        for (int i = 0; i < nbits; i++) begin
            idx = CL - 1 - i;
            for (int k = 0; k < NL; k++) d[k] = (idx >= 0) ? f[k][idx] : 1'($urandom);
            cyc(1'b1, d, (cmode == 2) && (i == nbits - 1));
        end
        if (cmode == 1) cyc(1'b0, '0, 1'b1);
    endtask

    task automatic do_reset();
        #2;
        nrst = 1'b0;
        model_reset();
        #1;
        check_ctl();
        check_route();
        @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    logic [SB*NM-1:0] all_f;

    initial begin
        all_f = '1;
        nrst = 1'b0; config_en = 0; config_data_in = '0; commit = 0;
        sb_bus_in = '0; cb_bus_in = '0; le_out = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_ctl();
        check_route();
        nrst = 1'b1;

        // idle pass-through after reset
        sb_bus_in = 8'h3C; cb_bus_in = 8'hA5; le_out = '0;
        #1;
        chk("idle_sb_pass", 32'(sb_bus_out), 32'h0A5);
        chk("idle_le_in", 32'(le_in), 32'h0);
        chk("idle_err", 32'(config_err), 32'h0);
        cyc(1'b0, '0, 1'b1);

        // LE0 in0 -> track 3, LE0 out -> track 5
        cfg(mkw(3, 15, 15, 15, 5), all_f, CL, 1'b0, 1);
        chk("done_pulse", 32'(config_done), 32'h1);
        cyc(1'b0, '0, 1'b0);
        chk("done_drop", 32'(config_done), 32'h0);
        sb_bus_in = 8'h08; cb_bus_in = 8'h00; le_out = 2'b01;
        #1;
        chk("le_in0_trk3", 32'(le_in[0]), 32'h1);
        chk("sb_out5", 32'(sb_bus_out[5]), 32'h1);
        chk("cb_out5", 32'(cb_bus_out[5]), 32'h1);

        // short chain -> error, routing kept
        cfg(mkw(1, 2, 3, 4, 6), mkw(7, 0, 1, 2, 3), CL - 1, 1'b0, 1);
        chk("err_short", 32'(config_err), 32'h1);

        // shared out track (LE0 wins), constant selectors
        cfg(mkw(0, W, W + 1, 15, 2), mkw(15, 15, 15, 15, 2), CL, 1'b0, 1);
        sb_bus_in = 8'hFF; cb_bus_in = 8'hFF; le_out = 2'b10;
        #1;
        chk("prio_sb2", 32'(sb_bus_out[2]), 32'h0);
        chk("prio_cb2", 32'(cb_bus_out[2]), 32'h0);
        chk("sel_zero", 32'(le_in[1]), 32'h0);
        chk("sel_one", 32'(le_in[2]), 32'h1);

        // reset mid-load, then a stray commit
        cfg(mkw(1, 1, 1, 1, 1), mkw(2, 2, 2, 2, 2), 10, 1'b0, 0);
        do_reset();
        cyc(1'b0, '0, 1'b1);
        chk("post_rst_le_in", 32'(le_in), 32'h0);

        // parity error then corrected bit
        if (PB == 1) begin
            cfg(mkw(4, 5, 6, 7, 1), mkw(0, 1, 2, 3, 4), CL, 1'b1, 1);
            cfg(mkw(4, 5, 6, 7, 1), mkw(0, 1, 2, 3, 4), CL, 1'b0, 1);
        end

        // randomized sequences
        for (int it = 0; it < 40; it++) begin
            int r, nb, cm;
            bit bad;
            r   = int'($urandom_range(0, 7));
            nb  = (r == 0) ? CL - 1 : (r == 1) ? CL + 1 : (r == 2) ? CL - 3 : CL;
            cm  = ($urandom_range(0, 7) == 0) ? 2 : ($urandom_range(0, 5) == 0 ? 0 : 1);
            bad = (PB == 1) && ($urandom_range(0, 3) == 0);
            cfg(mkw(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15))),
                mkw(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15))),
                nb, bad, cm);
            cyc(1'b0, '0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
